reticle_mux_i8_b_i8_i8: RTL and testbench
=========================================

# reticle_mux_i8_b_i8_i8

Combinational 2:1 selector on 8-bit operands, driven by a 1-bit condition: `y = cond ? t : f`. It is the generated-primitive form of the `mux` operation with type signature i8 ← (bool, i8, i8). The block sits in the datapath as a leaf cell. It carries the standard clock/reset pair so every generated primitive shares one interface shape, but it holds no state.

## Interface
- No parameters; all widths are fixed by the type signature.
- clock  input  1  system clock; present for interface uniformity; unused by the datapath.
- reset  input  1  asynchronous, active-low reset; present for interface uniformity; has no effect on `y`.
- cond  input  1  select; 1 selects `t`, 0 selects `f`.
- t  input  8  operand returned when `cond` = 1.
- f  input  8  operand returned when `cond` = 0.
- y  output  8  selected operand.

## Operation
- `y[i] = cond ? t[i] : f[i]` for every bit i in 0..7.
- Operands are opaque bit vectors. There is no sign or arithmetic interpretation and no width extension.
- Implementation: one 3-input function per bit with inputs (cond, t[i], f[i]), eight instances total. Equivalent to LUT3 truth table 0xCA with I0=f[i], I1=t[i], I2=cond.
- No registers, no state machine, no handshake.
- An unknown or high-impedance `cond` yields X on each bit where `t` and `f` differ.
- An unknown or high-impedance `cond` yields the common value on each bit where `t` and `f` are equal.

## Timing
- Latency 0 cycles: `y` follows `cond`, `t` and `f` combinationally within the same cycle.
- Clock edges do not change `y` unless inputs change.
- Reset value of `y`: none defined. `y` is always the mux function of the current inputs, whether reset is asserted, deasserted or toggled mid-operation.
- `reset` must not gate, force or delay `y`.
- Asserting `reset` (low) while inputs are stable leaves `y` unchanged.
- Simultaneous change of `cond` and an operand: `y` settles to the mux of the new values within the same cycle.
- Purely combinational path from inputs to `y`, with no feedback. Depth is one LUT level per bit.

## Test plan
- cond=0, t=0x02, f=0x06 -> y=0x06. Then cond=1 with t and f unchanged -> y=0x02 on the next sampled cycle.
- cond=1, t=0xFF, f=0x00 -> y=0xFF. Then cond=0 -> y=0x00. Checks every bit position in both directions.
- t=0xA5, f=0x5A, cond toggling every cycle for 16 cycles -> y alternates 0xA5/0x5A with zero lag.
- Hold cond=1, t=0x3C, f=0xC3. Assert reset low for 3 cycles, then release -> y=0x3C throughout, with no glitch to any reset value.
- With cond=0, change f from 0x11 to 0x80 mid-cycle, between clock edges -> y=0x80 before the next rising clock edge.
- Random sweep of 1000 vectors over (cond, t, f) -> y equals `cond ? t : f` on every vector.

Source files
------------

// File: rtl/reticle_mux_i8_b_i8_i8.sv
// 2:1 selector on 8-bit opaque operands: y = cond ? t : f.
// Stateless leaf cell; clock and reset exist only to match the shared primitive interface.
module reticle_mux_i8_b_i8_i8 (
    input  logic       clock,
    input  logic       reset,
    input  logic       cond,
    input  logic [7:0] t,
    input  logic [7:0] f,
    output logic [7:0] y
);

    // Tied off so the interface-only pins are visibly consumed without touching the datapath.
    logic unused_iface;
    assign unused_iface = clock & reset;

    // One 3-input function per bit (LUT3 0xCA: I0=f, I1=t, I2=cond).
    // The t&f consensus term keeps agreeing operand bits stable when cond is unknown.
    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign y[i] = (cond & t[i]) | (~cond & f[i]) | (t[i] & f[i]);
    end

endmodule

// File: tb/tb_reticle_mux_i8_b_i8_i8.sv
// Self-checking bench for reticle_mux_i8_b_i8_i8 against a behavioural select model.
module tb_reticle_mux_i8_b_i8_i8;

    logic       clock;
    logic       reset;
    logic       cond;
    logic [7:0] t;
    logic [7:0] f;
    logic [7:0] y;

    int vectors;
    int miscompares;

    reticle_mux_i8_b_i8_i8 dut (
        .clock (clock),
        .reset (reset),
        .cond  (cond),
        .t     (t),
        .f     (f),
        .y     (y)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] model(input logic c, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        if (c) r = a;
        else   r = b;
        return r;
    endfunction

    task automatic apply(input logic c, input logic [7:0] a, input logic [7:0] b);
        @(posedge clock);
        #1;
        cond = c;
        t    = a;
        f    = b;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        apply(1'b0, 8'h12, 8'h34);
        @(negedge clock);
        vectors++;
        if (y !== 8'h34) begin
            miscompares++;
            $display("FAIL reset_cond0: y=%02h expected=%02h", y, 8'h34);
        end
        apply(1'b1, 8'h12, 8'h34);
        @(negedge clock);
        vectors++;
        if (y !== 8'h12) begin
            miscompares++;
            $display("FAIL reset_cond1: y=%02h expected=%02h", y, 8'h12);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        apply(1'b0, 8'h02, 8'h06);
        @(negedge clock);
        vectors++;
        if (y !== 8'h06) begin
            miscompares++;
            $display("FAIL basic_f: y=%02h expected=%02h", y, 8'h06);
        end
        apply(1'b1, 8'h02, 8'h06);
        @(negedge clock);
        vectors++;
        if (y !== 8'h02) begin
            miscompares++;
            $display("FAIL basic_t: y=%02h expected=%02h", y, 8'h02);
        end
    endtask

    task automatic test_all_bits();
        apply(1'b1, 8'hFF, 8'h00);
        @(negedge clock);
        vectors++;
        if (y !== 8'hFF) begin
            miscompares++;
            $display("FAIL all_bits_ones: y=%02h expected=%02h", y, 8'hFF);
        end
        apply(1'b0, 8'hFF, 8'h00);
        @(negedge clock);
        vectors++;
        if (y !== 8'h00) begin
            miscompares++;
            $display("FAIL all_bits_zeros: y=%02h expected=%02h", y, 8'h00);
        end
        // Walking one through t, then through f, to catch per-bit faults.
        for (int i = 0; i < 8; i++) begin
            logic [7:0] w;
            w = 8'h01 << i;
            apply(1'b1, w, ~w);
            #1;
            vectors++;
            if (y !== w) begin
                miscompares++;
                $display("FAIL walk_t bit%0d: y=%02h expected=%02h", i, y, w);
            end
            cond = 1'b0;
            #1;
            vectors++;
            if (y !== ~w) begin
                miscompares++;
                $display("FAIL walk_f bit%0d: y=%02h expected=%02h", i, y, ~w);
            end
        end
    endtask

    task automatic test_toggle();
        logic c;
        c = 1'b0;
        for (int i = 0; i < 16; i++) begin
            c = ~c;
            apply(c, 8'hA5, 8'h5A);
            #1;
            vectors++;
            if (y !== (c ? 8'hA5 : 8'h5A)) begin
                miscompares++;
                $display("FAIL toggle cyc%0d: y=%02h expected=%02h", i, y, (c ? 8'hA5 : 8'h5A));
            end
        end
    endtask

    task automatic test_reset_hold();
        apply(1'b1, 8'h3C, 8'hC3);
        reset = 1'b0;
        #0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            vectors++;
            if (y !== 8'h3C) begin
                miscompares++;
                $display("FAIL reset_hold_rise cyc%0d: y=%02h expected=%02h", i, y, 8'h3C);
            end
            @(negedge clock);
            vectors++;
            if (y !== 8'h3C) begin
                miscompares++;
                $display("FAIL reset_hold_fall cyc%0d: y=%02h expected=%02h", i, y, 8'h3C);
            end
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (y !== 8'h3C) begin
            miscompares++;
            $display("FAIL reset_release: y=%02h expected=%02h", y, 8'h3C);
        end
        @(posedge clock);
        #1;
        vectors++;
        if (y !== 8'h3C) begin
            miscompares++;
            $display("FAIL reset_after: y=%02h expected=%02h", y, 8'h3C);
        end
    endtask

    task automatic test_midcycle();
        apply(1'b0, 8'h77, 8'h11);
        #1;
        vectors++;
        if (y !== 8'h11) begin
            miscompares++;
            $display("FAIL midcycle_before: y=%02h expected=%02h", y, 8'h11);
        end
        #2;
        f = 8'h80;
        #1;
        vectors++;
        if (y !== 8'h80) begin
            miscompares++;
            $display("FAIL midcycle_after: y=%02h expected=%02h", y, 8'h80);
        end
        // Simultaneous change of cond and operand between edges.
        cond = 1'b1;
        t    = 8'h9E;
        #1;
        vectors++;
        if (y !== 8'h9E) begin
            miscompares++;
            $display("FAIL midcycle_simul: y=%02h expected=%02h", y, 8'h9E);
        end
    endtask

    task automatic test_random();
        logic       c;
        logic [7:0] a;
        logic [7:0] b;
        for (int i = 0; i < 1000; i++) begin
            c = 1'($urandom_range(1, 0));
            a = 8'($urandom);
            b = 8'($urandom);
            reset = (i % 97 == 13) ? 1'b0 : 1'b1;
            apply(c, a, b);
            @(negedge clock);
            vectors++;
            if (y !== model(c, a, b)) begin
                miscompares++;
                $display("FAIL random #%0d c=%0b t=%02h f=%02h: y=%02h expected=%02h",
                         i, c, a, b, y, model(c, a, b));
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        cond        = 1'b0;
        t           = 8'h00;
        f           = 8'h00;
        test_reset();
        test_basic();
        test_all_bits();
        test_toggle();
        test_reset_hold();
        test_midcycle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
